// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared definitions for the fetch sequencer: FSM states, redirect sources, default vector.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pc_fetch_ctrl_pkg;

   // Sequencer states: one boot cycle, normal fetch, exception flush sequence.
   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_EXC  = 2'd2
   } state_e;

   // Source of a redirect, in priority order exc > branch > jump.
   typedef enum logic [1:0] {
      RD_NONE = 2'd0,
      RD_BR   = 2'd1,
      RD_JMP  = 2'd2,
      RD_EXC  = 2'd3
   } rd_src_e;

   localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0080;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Bundle between hazard/branch logic, imem, pc_reg and the fetch sequencer.
// Latency: n/a (wires only).
// Backpressure: imem_ready completes the fetch at the current PC; no ready means PC holds.
interface pc_fetch_ctrl_if;
   logic [31:0] pc;
   logic        stall;
   logic        br_taken;
   logic [31:0] br_target;
   logic        jmp;
   logic [31:0] jmp_target;
   logic        exc;
   logic        imem_ready;
   logic        imem_req;
   logic        pc_keep;
   logic        pc_jump;
   logic [31:0] pc_target;
   logic        flush_if_id;
   logic        flush_id_ex;
   logic [31:0] epc;

   // Environment side: pipeline, imem and pc_reg.
   modport master (
      output pc, stall, br_taken, br_target, jmp, jmp_target, exc, imem_ready,
      input  imem_req, pc_keep, pc_jump, pc_target, flush_if_id, flush_id_ex, epc
   );

   // Sequencer side.
   modport slave (
      input  pc, stall, br_taken, br_target, jmp, jmp_target, exc, imem_ready,
      output imem_req, pc_keep, pc_jump, pc_target, flush_if_id, flush_id_ex, epc
   );
endinterface

// File: rtl/pc_fetch_ctrl_redirect_buf.sv
// Single-entry slot holding a redirect that arrived while fetch could not advance.
// Latency: set/clear take effect on the next edge; slot contents are visible combinationally.
// Backpressure: none; the caller only sets an empty slot and kill overrides everything.
module pc_redirect_buf (
   input  logic        clk,
   input  logic        rst,
   input  logic        set_i,
   input  logic        clr_i,
   input  logic        kill_i,
   input  logic [31:0] tgt_i,
   output logic        pend_v_o,
   output logic [31:0] pend_tgt_o
);

   logic        pend_v_q, pend_v_d;
   logic [31:0] pend_tgt_q, pend_tgt_d;

   // Next slot contents: kill beats clear beats set.
   always_comb begin
      pend_v_d   = pend_v_q;
      pend_tgt_d = pend_tgt_q;
      if (kill_i) begin
         pend_v_d = 1'b0;
      end else if (clr_i) begin
         pend_v_d = 1'b0;
      end else if (set_i) begin
         pend_v_d   = 1'b1;
         pend_tgt_d = tgt_i;
      end
   end

   // Slot registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend_v_q   <= 1'b0;
         pend_tgt_q <= '0;
      end else begin
         pend_v_q   <= pend_v_d;
         pend_tgt_q <= pend_tgt_d;
      end
   end

   assign pend_v_o   = pend_v_q;
   assign pend_tgt_o = pend_tgt_q;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer driving pc_reg keep/jump/target from stall, branch, jump and exception events.
// Latency: outputs combinational from state/regs/inputs; redirects apply on the first advancing edge.
// Backpressure: PC holds while imem_ready=0 or stall=1; a redirect seen then is parked in one slot.
module pc_fetch_ctrl
   import pc_fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR   = DEF_EXC_VECTOR,
   parameter int          FLUSH_CYCLES = 3
) (
   input  logic            clk,
   input  logic            rst,
   pc_fetch_ctrl_if.slave  bus
);

   localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FLUSH_CYCLES - 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       epc_q, epc_d;

   logic              pend_v;
   logic [31:0]       pend_tgt;
   logic              buf_set, buf_clr, buf_kill;

   rd_src_e           rd_src;
   logic [31:0]       rd_tgt;
   logic              new_rd;
   logic              adv;

   logic              imem_req_c, pc_keep_c, pc_jump_c;
   logic [31:0]       pc_target_c;
   logic              flush_if_id_c, flush_id_ex_c;

   pc_redirect_buf u_rd_buf (
      .clk        (clk),
      .rst        (rst),
      .set_i      (buf_set),
      .clr_i      (buf_clr),
      .kill_i     (buf_kill),
      .tgt_i      (rd_tgt),
      .pend_v_o   (pend_v),
      .pend_tgt_o (pend_tgt)
   );

   // Pick the pipeline redirect: an EX branch is older than an ID jump, so it wins.
   always_comb begin
      rd_src = RD_NONE;
      rd_tgt = '0;
      if (bus.br_taken) begin
         rd_src = RD_BR;
         rd_tgt = bus.br_target;
      end else if (bus.jmp) begin
         rd_src = RD_JMP;
         rd_tgt = bus.jmp_target;
      end
   end

   // A parked redirect already flushed the younger sources, so new ones are ignored meanwhile.
   assign new_rd = (rd_src != RD_NONE) && !pend_v;
   assign adv    = bus.imem_ready && !bus.stall;

   // Next state and all fetch controls.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      epc_d         = epc_q;
      imem_req_c    = 1'b0;
      pc_keep_c     = 1'b1;
      pc_jump_c     = 1'b0;
      pc_target_c   = '0;
      flush_if_id_c = 1'b0;
      flush_id_ex_c = 1'b0;
      buf_set       = 1'b0;
      buf_clr       = 1'b0;
      buf_kill      = 1'b0;

      case (state_q)
         ST_BOOT: begin
            // Hold the PC reset value for one cycle; exceptions are not yet meaningful.
            state_d = ST_RUN;
         end

         ST_RUN: begin
            imem_req_c = 1'b1;
            if (bus.exc) begin
               // Exception drops any concurrent redirect or stall and holds the PC.
               epc_d         = bus.pc;
               cnt_d         = CNT_RELOAD;
               buf_kill      = 1'b1;
               flush_if_id_c = 1'b1;
               flush_id_ex_c = 1'b1;
               state_d       = ST_EXC;
            end else begin
               pc_keep_c = !adv;
               if (pend_v) begin
                  // Anything fetched ahead of the parked redirect is wrong-path.
                  flush_if_id_c = bus.imem_ready;
                  if (adv) begin
                     pc_jump_c   = 1'b1;
                     pc_target_c = pend_tgt;
                     buf_clr     = 1'b1;
                  end
               end else if (new_rd) begin
                  flush_if_id_c = 1'b1;
                  flush_id_ex_c = (rd_src == RD_BR);
                  if (adv) begin
                     pc_jump_c   = 1'b1;
                     pc_target_c = rd_tgt;
                  end else begin
                     buf_set = 1'b1;
                  end
               end
            end
         end

         ST_EXC: begin
            flush_if_id_c = 1'b1;
            flush_id_ex_c = 1'b1;
            if (bus.exc) begin
               // A nested exception restarts the drain and records the newer PC.
               epc_d    = bus.pc;
               cnt_d    = CNT_RELOAD;
               buf_kill = 1'b1;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               // Vector regardless of stall: the pipeline is empty by now.
               pc_keep_c   = 1'b0;
               pc_jump_c   = 1'b1;
               pc_target_c = EXC_VECTOR;
               state_d     = ST_RUN;
            end
         end

         default: begin
            state_d = ST_BOOT;
         end
      endcase
   end

   // Sequencer state, drain counter and exception PC.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_BOOT;
         cnt_q   <= '0;
         epc_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         epc_q   <= epc_d;
      end
   end

   assign bus.imem_req    = imem_req_c;
   assign bus.pc_keep     = pc_keep_c;
   assign bus.pc_jump     = pc_jump_c;
   assign bus.pc_target   = pc_target_c;
   assign bus.flush_if_id = flush_if_id_c;
   assign bus.flush_id_ex = flush_id_ex_c;
   assign bus.epc         = epc_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed and random stimulus for pc_fetch_ctrl, checked cycle by cycle against a behavioural model.
// Latency: model outputs compared mid-cycle; PC advanced by a pc_reg stand-in after each edge.
// Backpressure: imem_ready and stall are driven directly by the bench.
module tb_pc_fetch_ctrl;

   localparam logic [31:0] EXC_VEC = 32'h0000_0080;
   localparam int          FC      = 3;

   logic clk = 1'b0;
   logic rst;

   pc_fetch_ctrl_if bus ();

   pc_fetch_ctrl #(
      .EXC_VECTOR   (EXC_VEC),
      .FLUSH_CYCLES (FC)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Behavioural model: booting flag, exception cycles left, queue of parked targets, epc.
   bit          m_boot;
   int          m_exc_left;
   logic [31:0] m_pend[$];
   logic [31:0] m_epc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic st, input logic rdy, input logic br, input logic [31:0] bt,
                        input logic j, input logic [31:0] jt, input logic e);
      bus.stall      = st;
      bus.imem_ready = rdy;
      bus.br_taken   = br;
      bus.br_target  = bt;
      bus.jmp        = j;
      bus.jmp_target = jt;
      bus.exc        = e;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req"},    {31'd0, bus.imem_req},    32'd0);
      chk({tag, "_keep"},   {31'd0, bus.pc_keep},     32'd1);
      chk({tag, "_jump"},   {31'd0, bus.pc_jump},     32'd0);
      chk({tag, "_target"}, bus.pc_target,            32'd0);
      chk({tag, "_fifid"},  {31'd0, bus.flush_if_id}, 32'd0);
      chk({tag, "_fidex"},  {31'd0, bus.flush_id_ex}, 32'd0);
      chk({tag, "_epc"},    bus.epc,                  32'd0);
   endtask

   // Assert reset away from the clock edge and check outputs respond without a clock.
   task automatic do_reset(input string tag);
      #2 rst = 1'b0;
      #1;
      chk_reset_outputs(tag);
      m_boot     = 1'b1;
      m_exc_left = 0;
      m_pend.delete();
      m_epc      = '0;
      bus.pc     = '0;
      drive(0, 1, 0, '0, 0, '0, 0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
   endtask

   // One clock: compare against the model mid-cycle, then advance model and PC after the edge.
   task automatic cycle();
      logic        e_req, e_keep, e_jump, e_fif, e_fie;
      logic [31:0] e_tgt, npc, nepc, want;
      bit          nboot, do_pop, do_push, do_flushq, adv;
      int          nexc;
      @(negedge clk);
      e_req = 0; e_keep = 1; e_jump = 0; e_tgt = '0; e_fif = 0; e_fie = 0;
      nboot = m_boot; nexc = m_exc_left; nepc = m_epc;
      do_pop = 0; do_push = 0; do_flushq = 0; want = '0;
      if (m_boot) begin
         nboot = 0;
      end else if (m_exc_left > 0) begin
         e_fif = 1; e_fie = 1;
         if (bus.exc) begin
            nexc = FC; nepc = bus.pc;
         end else if (m_exc_left > 1) begin
            nexc = m_exc_left - 1;
         end else begin
            e_keep = 0; e_jump = 1; e_tgt = EXC_VEC; nexc = 0;
         end
      end else begin
         e_req = 1;
         if (bus.exc) begin
            e_fif = 1; e_fie = 1; nexc = FC; nepc = bus.pc; do_flushq = 1;
         end else begin
            adv    = bus.imem_ready && !bus.stall;
            e_keep = !adv;
            if (m_pend.size() != 0) begin
               e_fif = bus.imem_ready;
               if (adv) begin
                  e_jump = 1; e_tgt = m_pend[0]; do_pop = 1;
               end
            end else if (bus.br_taken || bus.jmp) begin
               want  = bus.br_taken ? bus.br_target : bus.jmp_target;
               e_fif = 1;
               e_fie = bus.br_taken;
               if (adv) begin
                  e_jump = 1; e_tgt = want;
               end else begin
                  do_push = 1;
               end
            end
         end
      end
      chk("imem_req",    {31'd0, bus.imem_req},    {31'd0, e_req});
      chk("pc_keep",     {31'd0, bus.pc_keep},     {31'd0, e_keep});
      chk("pc_jump",     {31'd0, bus.pc_jump},     {31'd0, e_jump});
      chk("pc_target",   bus.pc_target,            e_tgt);
      chk("flush_if_id", {31'd0, bus.flush_if_id}, {31'd0, e_fif});
      chk("flush_id_ex", {31'd0, bus.flush_id_ex}, {31'd0, e_fie});
      chk("epc",         bus.epc,                  m_epc);
      // pc_reg stand-in, driven by what the DUT actually asked for.
      npc = bus.pc_keep ? bus.pc : (bus.pc_jump ? bus.pc_target : bus.pc + 32'd4);
      @(posedge clk);
      m_boot     = nboot;
      m_exc_left = nexc;
      m_epc      = nepc;
      if (do_flushq) m_pend.delete();
      if (do_pop)    void'(m_pend.pop_front());
      if (do_push)   m_pend.push_back(want);
      #1;
      bus.pc = npc;
   endtask

   initial begin
      rst = 1'b0;
      bus.pc = '0;
      drive(0, 1, 0, '0, 0, '0, 0);
      #1;
      do_reset("reset0");

      // Boot holds PC for one cycle, then sequential fetch.
      cycle();
      chk("boot_pc", bus.pc, 32'h0);
      for (int i = 1; i <= 4; i++) begin
         cycle();
         chk("seq_pc", bus.pc, 32'(i * 4));
      end

      // Stall at 0x10 for three cycles.
      drive(1, 1, 0, '0, 0, '0, 0);
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("stall_pc", bus.pc, 32'h10);
      end
      drive(0, 1, 0, '0, 0, '0, 0);
      cycle();
      chk("after_stall_pc", bus.pc, 32'h14);

      // Branch beats simultaneous jump.
      drive(0, 1, 1, 32'h200, 1, 32'h300, 0);
      cycle();
      chk("br_over_jmp_pc", bus.pc, 32'h200);

      // Jump parked while imem not ready; a branch during the wait is ignored.
      drive(0, 0, 0, '0, 1, 32'h40, 0);
      cycle();
      chk("pend_hold_pc", bus.pc, 32'h200);
      drive(0, 0, 1, 32'h500, 0, '0, 0);
      cycle();
      chk("pend_hold_pc2", bus.pc, 32'h200);
      drive(0, 1, 0, '0, 0, '0, 0);
      cycle();
      chk("pend_apply_pc", bus.pc, 32'h40);

      // Exception at 0x24 with a parked redirect, re-pulsed mid-sequence.
      drive(0, 1, 0, '0, 1, 32'h24, 0);
      cycle();
      chk("to_24_pc", bus.pc, 32'h24);
      drive(0, 0, 0, '0, 1, 32'h100, 0);
      cycle();
      drive(0, 1, 0, '0, 0, '0, 1);
      cycle();
      chk("exc_epc", bus.epc, 32'h24);
      drive(0, 1, 0, '0, 0, '0, 0);
      cycle();
      drive(0, 1, 0, '0, 0, '0, 1);
      cycle();
      drive(1, 1, 0, '0, 0, '0, 0);
      cycle();
      cycle();
      chk("exc_hold_pc", bus.pc, 32'h24);
      cycle();
      chk("exc_vector_pc", bus.pc, EXC_VEC);
      drive(0, 1, 0, '0, 0, '0, 0);
      cycle();
      chk("no_stale_pend_pc", bus.pc, EXC_VEC + 32'd4);

      // Reset in the middle of an exception drain.
      drive(0, 1, 0, '0, 0, '0, 1);
      cycle();
      drive(0, 1, 0, '0, 0, '0, 0);
      cycle();
      do_reset("reset_in_exc");
      cycle();
      chk("post_rst_boot_pc", bus.pc, 32'h0);
      cycle();
      chk("post_rst_pc", bus.pc, 32'h4);

      // Reset while a redirect is parked.
      drive(0, 0, 0, '0, 1, 32'h300, 0);
      cycle();
      do_reset("reset_in_pend");
      cycle();
      chk("post_rst2_boot_pc", bus.pc, 32'h0);
      cycle();
      chk("post_rst2_pc", bus.pc, 32'h4);

      // Random traffic against the model.
      for (int i = 0; i < 600; i++) begin
         drive(($urandom_range(3) == 0), ($urandom_range(9) < 7),
               ($urandom_range(9) == 0), {$urandom_range(32'hFFFF), 2'b00},
               ($urandom_range(9) == 0), {$urandom_range(32'hFFFF), 2'b00},
               ($urandom_range(29) == 0));
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
